// File: rtl/mux_scan_sequencer.sv
// Scan controller for an 8-to-1 (2**SEL_W-to-1) mux: walks sel_out over every channel,
// samples mux_in and presents the assembled frame on a valid/ready handshake.
// Optional even-parity output guarded by `MUX_SCAN_PARITY_EN.
module mux_scan_sequencer #(
  parameter int SEL_W  = 3,
  parameter int SETTLE = 1,
  localparam int NUM_CH = 2 ** SEL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mux_in,
  output logic [SEL_W-1:0]  sel_out,
  output logic              busy,
  output logic              frame_valid,
  output logic [NUM_CH-1:0] frame_data,
`ifdef MUX_SCAN_PARITY_EN
  output logic              frame_parity,
`endif
  input  logic              frame_ready
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0]       SETTLE_V = 4'(SETTLE);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);
  localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_ZERO = SEL_W'(0);
  // With no settle time a channel goes straight to its sample cycle.
  localparam state_t ENTRY_ST = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

  state_t              state_r;
  logic [3:0]          cnt_r;
  logic [SEL_W-1:0]    sel_r;
  logic                busy_r;
  logic                valid_r;
  logic [NUM_CH-1:0]   frame_r;
  logic [NUM_CH-1:0]   sample_frame_s;

  function automatic logic even_parity(input logic [NUM_CH-1:0] vec);
    logic p;
    p = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      p = p ^ vec[i];
    end
    return p;
  endfunction

  // Frame as it will look once the current channel's sample is written in.
  always_comb begin
    sample_frame_s         = frame_r;
    sample_frame_s[sel_r]  = mux_in;
  end

  // Scan state machine with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      sel_r   <= SEL_ZERO;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      frame_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            sel_r   <= SEL_ZERO;
            cnt_r   <= SETTLE_V;
            frame_r <= '0;
            busy_r  <= 1'b1;
            state_r <= ENTRY_ST;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (cnt_r <= 4'd1) begin
            cnt_r   <= 4'd0;
            state_r <= ST_SAMPLE;
          end else begin
            cnt_r   <= cnt_r - 4'd1;
          end
        end
        ST_SAMPLE: begin
          frame_r <= sample_frame_s;
          if (sel_r == LAST_SEL) begin
            sel_r   <= SEL_ZERO;
            valid_r <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            sel_r   <= sel_r + SEL_ONE;
            cnt_r   <= SETTLE_V;
            state_r <= ENTRY_ST;
          end
        end
        ST_DONE: begin
          // start is deliberately not looked at here, even on the handshake edge.
          if (valid_r && frame_ready) begin
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            valid_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          valid_r <= 1'b0;
          sel_r   <= SEL_ZERO;
          cnt_r   <= 4'd0;
        end
      endcase
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  logic parity_r;

  // Parity captured on the same edge as the last channel's sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && start) begin
      parity_r <= 1'b0;
    end else if ((state_r == ST_SAMPLE) && (sel_r == LAST_SEL)) begin
      parity_r <= even_parity(sample_frame_s);
    end else begin
      parity_r <= parity_r;
    end
  end

  assign frame_parity = parity_r;
`else
  // Parity-free build: frames carry data bits only.
`endif

  assign sel_out     = sel_r;
  assign busy        = busy_r;
  assign frame_valid = valid_r;
  assign frame_data  = frame_r;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench: two sequencers (SETTLE=1 and SETTLE=0) around modelled muxes, driven by a vector
// table, randomized frames and hand-written reset/back-to-back sequences.
module tb_mux_scan_sequencer;

  localparam int NUM_CH = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start_a, start_b, ready_a, ready_b;
  logic [7:0] data_a, data_b;
  logic [2:0] sel_a, sel_b;
  logic       busy_a, busy_b, valid_a, valid_b;
  logic [7:0] frame_a, frame_b;
  logic       mux_a, mux_b;
  logic       par_a, par_b;

  // Mux models: out = data_in[sel]
  assign mux_a = data_a[sel_a];
  assign mux_b = data_b[sel_b];

  mux_scan_sequencer #(.SEL_W(3), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .mux_in(mux_a),
    .sel_out(sel_a), .busy(busy_a), .frame_valid(valid_a), .frame_data(frame_a),
`ifdef MUX_SCAN_PARITY_EN
    .frame_parity(par_a),
`endif
    .frame_ready(ready_a)
  );

  mux_scan_sequencer #(.SEL_W(3), .SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .mux_in(mux_b),
    .sel_out(sel_b), .busy(busy_b), .frame_valid(valid_b), .frame_data(frame_b),
`ifdef MUX_SCAN_PARITY_EN
    .frame_parity(par_b),
`endif
    .frame_ready(ready_b)
  );

`ifndef MUX_SCAN_PARITY_EN
  assign par_a = 1'b0;
  assign par_b = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int         which;
    logic [7:0] data;
    int         hold;
    logic [7:0] exp_frame;
    logic       exp_par;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int which, input logic st, input logic rd, input logic [7:0] d);
    if (which == 0) begin
      start_a = st; ready_a = rd; data_a = d;
    end else begin
      start_b = st; ready_b = rd; data_b = d;
    end
  endtask

  function automatic logic [2:0] sel_of(input int which);
    return (which == 0) ? sel_a : sel_b;
  endfunction
  function automatic logic valid_of(input int which);
    return (which == 0) ? valid_a : valid_b;
  endfunction
  function automatic logic busy_of(input int which);
    return (which == 0) ? busy_a : busy_b;
  endfunction
  function automatic logic [7:0] frame_of(input int which);
    return (which == 0) ? frame_a : frame_b;
  endfunction
  function automatic logic par_of(input int which);
    return (which == 0) ? par_a : par_b;
  endfunction

  // Reference: channel i is sampled while the mux shows data[i]
  function automatic logic [7:0] model_frame(input logic [7:0] d);
    logic [7:0] f;
    for (int i = 0; i < NUM_CH; i++) f[i] = d[i];
    return f;
  endfunction

  function automatic logic model_parity(input logic [7:0] f);
    return ($countones(f) % 2) == 1;
  endfunction

  // One complete scan with cycle-exact timing, backpressure and handshake.
  task automatic run_frame(input int which, input logic [7:0] d, input int hold,
                           input logic [7:0] exp_frame, input logic exp_par);
    int s;
    int cyc;
    s   = (which == 0) ? 1 : 0;
    cyc = NUM_CH * (s + 1);
    set_in(which, 1'b1, 1'b0, d);
    tick();
    set_in(which, 1'b0, 1'b0, d);
    for (int k = 0; k < cyc; k++) begin
      check("scan_sel", 32'(sel_of(which)), 32'(k / (s + 1)));
      check("scan_valid_low", 32'(valid_of(which)), 32'd0);
      check("scan_busy", 32'(busy_of(which)), 32'd1);
      tick();
    end
    check("valid_rise", 32'(valid_of(which)), 32'd1);
    check("frame_data", 32'(frame_of(which)), 32'(exp_frame));
    check("sel_wrap", 32'(sel_of(which)), 32'd0);
`ifdef MUX_SCAN_PARITY_EN
    check("frame_parity", 32'(par_of(which)), 32'(exp_par));
`endif
    for (int h = 0; h < hold; h++) begin
      set_in(which, h[0], 1'b0, d);
      tick();
      check("hold_valid", 32'(valid_of(which)), 32'd1);
      check("hold_data", 32'(frame_of(which)), 32'(exp_frame));
      check("hold_busy", 32'(busy_of(which)), 32'd1);
    end
    set_in(which, 1'b1, 1'b1, d);
    tick();
    set_in(which, 1'b0, 1'b0, d);
    check("hs_valid_low", 32'(valid_of(which)), 32'd0);
    check("hs_idle", 32'(busy_of(which)), 32'd0);
    check("hs_data_kept", 32'(frame_of(which)), 32'(exp_frame));
    tick();
    check("idle_after_hs", 32'(busy_of(which)), 32'd0);
  endtask

  vec_t vecs[5];

  initial begin
    logic [7:0] rd;
    int         rw;
    vecs[0] = '{which: 0, data: 8'hA5, hold: 10, exp_frame: 8'hA5, exp_par: 1'b0};
    vecs[1] = '{which: 1, data: 8'h3C, hold: 0,  exp_frame: 8'h3C, exp_par: 1'b0};
    vecs[2] = '{which: 0, data: 8'hFF, hold: 0,  exp_frame: 8'hFF, exp_par: 1'b0};
    vecs[3] = '{which: 0, data: 8'h01, hold: 2,  exp_frame: 8'h01, exp_par: 1'b1};
    vecs[4] = '{which: 1, data: 8'h81, hold: 3,  exp_frame: 8'h81, exp_par: 1'b0};

    rst_n = 1'b0;
    set_in(0, 1'b0, 1'b0, 8'h00);
    set_in(1, 1'b0, 1'b0, 8'h00);
    #2;
    check("rst_sel", 32'(sel_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_frame", 32'(frame_a), 32'd0);
    check("rst_busy0", 32'(busy_b), 32'd0);
    #10;
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) begin
      run_frame(vecs[v].which, vecs[v].data, vecs[v].hold, vecs[v].exp_frame, vecs[v].exp_par);
    end

    // Mid-scan asynchronous reset while sel_out==4
    set_in(0, 1'b1, 1'b0, 8'h5A);
    tick();
    set_in(0, 1'b0, 1'b0, 8'h5A);
    for (int k = 0; k < 8; k++) tick();
    check("midscan_sel4", 32'(sel_a), 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_sel", 32'(sel_a), 32'd0);
    check("async_busy", 32'(busy_a), 32'd0);
    check("async_valid", 32'(valid_a), 32'd0);
    check("async_frame", 32'(frame_a), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_no_valid", 32'(valid_a), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", 32'(busy_a), 32'd0);
    run_frame(0, 8'h81, 0, 8'h81, 1'b0);

    // Back-to-back frames with one IDLE cycle between
    run_frame(0, 8'hFF, 0, 8'hFF, 1'b0);
    run_frame(0, 8'h01, 0, 8'h01, 1'b1);

    // Randomized frames against the reference model
    for (int r = 0; r < 20; r++) begin
      rw = int'($urandom_range(0, 1));
      rd = 8'($urandom);
      run_frame(rw, rd, int'($urandom_range(0, 4)), model_frame(rd), model_parity(model_frame(rd)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
